// File: rtl/reg_inst_issue_ctrl.sv
// reg_inst_issue_ctrl
// Issue controller and register scoreboard for decoded R-type instructions
// heading into a fixed-latency pipelined ALU. Tracks pending destination
// writes, stalls on RAW/WAW hazards, and emits a writeback strobe
// ALU_LATENCY cycles after issue.
// Optional feature macro: REG_INST_FORWARDING_EN. When it is defined, the
// register being written back this cycle is not treated as a hazard.
module reg_inst_issue_ctrl #(
    parameter int ALU_LATENCY = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_alu_control,
    output logic                   issue_valid,
    output logic [4:0]             issue_rs1,
    output logic [4:0]             issue_rs2,
    output logic [4:0]             issue_rd,
    output logic [4:0]             issue_alu_control,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [31:0]            r_pending;
    logic                   r_issue_valid;
    logic [4:0]             r_issue_rs1;
    logic [4:0]             r_issue_rs2;
    logic [4:0]             r_issue_rd;
    logic [4:0]             r_issue_alu;
    logic [ALU_LATENCY-1:0] r_stg_valid;
    logic [4:0]             r_stg_rd [ALU_LATENCY];
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic        w_wb_valid;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_mask;
    logic [31:0] w_pend_eff;
    logic [31:0] w_pend_next;
    logic        w_hazard;
    logic        w_accept;

    assign w_wb_valid = r_stg_valid[ALU_LATENCY-1];
    assign w_wb_rd    = r_stg_rd[ALU_LATENCY-1];

    // Hazard detection against the (optionally bypass-adjusted) scoreboard.
    always_comb begin
        w_wb_mask = 32'd0;
        if (w_wb_valid && (w_wb_rd != 5'd0))
            w_wb_mask[w_wb_rd] = 1'b1;
`ifdef REG_INST_FORWARDING_EN
        w_pend_eff = r_pending & ~w_wb_mask;
`else
        w_pend_eff = r_pending;
`endif
        w_hazard = ((in_rs1 != 5'd0) && w_pend_eff[in_rs1]) ||
                   ((in_rs2 != 5'd0) && w_pend_eff[in_rs2]) ||
                   ((in_rd  != 5'd0) && w_pend_eff[in_rd]);
    end

    // rst_n gates ready so every output reads 0 while reset is held.
    assign in_ready = rst_n & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    // Next scoreboard: clear the written-back register, then set the new
    // destination so a same-cycle re-target keeps the register pending.
    always_comb begin
        w_pend_next = r_pending & ~w_wb_mask;
        if (w_accept && (in_rd != 5'd0))
            w_pend_next[in_rd] = 1'b1;
    end

    // Scoreboard register; flush kills every outstanding write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pending <= 32'd0;
        else if (flush)
            r_pending <= 32'd0;
        else
            r_pending <= w_pend_next;
    end

    // Issue register loads on every handshake and strobes for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_rs1   <= 5'd0;
            r_issue_rs2   <= 5'd0;
            r_issue_rd    <= 5'd0;
            r_issue_alu   <= 5'd0;
        end else begin
            r_issue_valid <= w_accept;
            if (w_accept) begin
                r_issue_rs1 <= in_rs1;
                r_issue_rs2 <= in_rs2;
                r_issue_rd  <= in_rd;
                r_issue_alu <= in_alu_control;
            end
        end
    end

    // ALU shadow pipeline fed from the issue register; last stage is writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= '0;
            for (int i = 0; i < ALU_LATENCY; i++)
                r_stg_rd[i] <= 5'd0;
        end else begin
            r_stg_valid[0] <= r_issue_valid & ~flush;
            r_stg_rd[0]    <= r_issue_rd;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                r_stg_valid[i] <= r_stg_valid[i-1] & ~flush;
                r_stg_rd[i]    <= r_stg_rd[i-1];
            end
        end
    end

    // Saturating count of offered-but-refused cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_count <= '0;
        else if (in_valid && !in_ready && (r_stall_count != {STALL_CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign issue_valid       = r_issue_valid;
    assign issue_rs1         = r_issue_rs1;
    assign issue_rs2         = r_issue_rs2;
    assign issue_rd          = r_issue_rd;
    assign issue_alu_control = r_issue_alu;
    assign wb_valid          = w_wb_valid;
    assign wb_rd             = w_wb_rd;
    assign busy              = (|r_pending) | r_issue_valid | (|r_stg_valid);
    assign stall_count       = r_stall_count;

endmodule

// File: tb/tb_reg_inst_issue_ctrl.sv
// Bench for reg_inst_issue_ctrl: transaction-level model of in-flight
// instructions, per-cycle compare, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_reg_inst_issue_ctrl;

    localparam int L = 2;
`ifdef REG_INST_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_alu = '0;

    logic        in_ready, issue_valid, wb_valid, busy;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, issue_alu, wb_rd;
    logic [15:0] stall_count;

    logic        b_in_ready, b_issue_valid, b_wb_valid, b_busy;
    logic [4:0]  b_issue_rs1, b_issue_rs2, b_issue_rd, b_issue_alu, b_wb_rd;
    logic [3:0]  b_stall_count;

    always #5 clk = ~clk;

    reg_inst_issue_ctrl #(.ALU_LATENCY(L), .STALL_CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_control(in_alu), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_alu_control(issue_alu), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy(busy), .stall_count(stall_count)
    );

    reg_inst_issue_ctrl #(.ALU_LATENCY(L), .STALL_CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_control(in_alu), .issue_valid(b_issue_valid),
        .issue_rs1(b_issue_rs1), .issue_rs2(b_issue_rs2), .issue_rd(b_issue_rd),
        .issue_alu_control(b_issue_alu), .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
        .busy(b_busy), .stall_count(b_stall_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted instruction is in flight from the end of its
    // accept cycle through its writeback cycle (accept + 1 + L).
    typedef struct {
        int rd; int rs1; int rs2; int alu; int acc; int wb;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   m_stall = 0;
    int   m_stall4 = 0;
    bit   chk_en = 1'b0;

    always @(negedge clk) begin : compare
        logic [31:0] pend;
        bit   e_wbv, e_iv, haz, e_rdy, acc;
        int   e_wbrd, e_rs1, e_rs2, e_rd, e_alu;
        ent_t nq[$];
        ent_t ne;
        if (chk_en) begin
            pend = '0; e_wbv = 0; e_iv = 0;
            e_wbrd = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_alu = 0;
            foreach (q[i]) begin
                if (q[i].wb == cyc) begin e_wbv = 1; e_wbrd = q[i].rd; end
                if (q[i].acc == cyc - 1) begin
                    e_iv = 1; e_rs1 = q[i].rs1; e_rs2 = q[i].rs2;
                    e_rd = q[i].rd; e_alu = q[i].alu;
                end
                if (q[i].rd != 0 && !(FWD && q[i].wb == cyc)) pend[q[i].rd] = 1'b1;
            end
            haz = (in_rs1 != 0 && pend[in_rs1]) || (in_rs2 != 0 && pend[in_rs2]) ||
                  (in_rd != 0 && pend[in_rd]);
            e_rdy = !haz && !flush;

            chk("in_ready", in_ready, e_rdy);
            chk("in_ready_w4", b_in_ready, e_rdy);
            chk("issue_valid", issue_valid, e_iv);
            if (e_iv) begin
                chk("issue_rs1", issue_rs1, e_rs1);
                chk("issue_rs2", issue_rs2, e_rs2);
                chk("issue_rd", issue_rd, e_rd);
                chk("issue_alu", issue_alu, e_alu);
            end
            chk("wb_valid", wb_valid, e_wbv);
            if (e_wbv) chk("wb_rd", wb_rd, e_wbrd);
            chk("busy", busy, q.size() != 0);
            chk("stall_count", stall_count, m_stall);
            chk("stall_count_w4", b_stall_count, m_stall4);

            acc = in_valid && e_rdy;
            if (in_valid && !e_rdy) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            nq.delete();
            if (!flush)
                foreach (q[i]) if (q[i].wb != cyc) nq.push_back(q[i]);
            if (acc) begin
                ne.rd = in_rd; ne.rs1 = in_rs1; ne.rs2 = in_rs2; ne.alu = in_alu;
                ne.acc = cyc; ne.wb = cyc + 1 + L;
                nq.push_back(ne);
            end
            q = nq;
            cyc++;
        end
    end

    task automatic drv(input bit v, input int rs1, input int rs2, input int rd,
                       input int alu, input bit fl);
        @(posedge clk);
        #1;
        in_valid = v; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0];
        in_rd = rd[4:0]; in_alu = alu[4:0]; flush = fl;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_rd", issue_rd, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall_count_w4", b_stall_count, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        q.delete(); cyc = 0; m_stall = 0; m_stall4 = 0;
        chk_en = 1'b1;
    endtask

    // Offer one instruction until accepted (bounded), counting refused cycles.
    task automatic offer_wait(input int rs1, input int rs2, input int rd, input int alu,
                              output int stalls, output bit got);
        stalls = 0; got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            drv(1, rs1, rs2, rd, alu, 0);
            #1;
            if (in_ready) got = 1; else stalls++;
        end
    endtask

    int stalls;
    bit got;

    initial begin
        do_reset();

        // Independent pair
        drv(1, 1, 2, 3, 0, 0); #1; chk("pair_rdy0", in_ready, 1);
        drv(1, 5, 6, 4, 1, 0); #1; chk("pair_rdy1", in_ready, 1);
        chk("pair_c1_iv", issue_valid, 1); chk("pair_c1_rd", issue_rd, 3);
        idle(); #1; chk("pair_c2_iv", issue_valid, 1); chk("pair_c2_rd", issue_rd, 4);
        chk("pair_c2_wb", wb_valid, 0);
        idle(); #1; chk("pair_c3_wb", wb_valid, 1); chk("pair_c3_rd", wb_rd, 3);
        idle(); #1; chk("pair_c4_wb", wb_valid, 1); chk("pair_c4_rd", wb_rd, 4);
        idle(); #1; chk("pair_c5_wb", wb_valid, 0);
        repeat (3) idle();

        // RAW
        do_reset();
        drv(1, 1, 2, 3, 0, 0); #1; chk("raw_rdy0", in_ready, 1);
        offer_wait(3, 1, 5, 4, stalls, got);
        chk("raw_accepted", got, 1);
        chk("raw_stalls", stalls, FWD ? 2 : 3);
        idle(); #1; chk("raw_stall_count", stall_count, FWD ? 2 : 3);
        repeat (6) idle();

        // WAW
        drv(1, 1, 2, 7, 3, 0); #1; chk("waw_rdy0", in_ready, 1);
        offer_wait(3, 4, 7, 5, stalls, got);
        chk("waw_accepted", got, 1);
        chk("waw_stalls", stalls, FWD ? 2 : 3);
        repeat (6) idle();

        // x0 never stalls
        for (int k = 0; k < 6; k++) begin
            drv(1, 0, 0, 0, 0, 0); #1; chk("x0_rdy", in_ready, 1);
        end
        repeat (6) idle();
        #1; chk("x0_drained_busy", busy, 0);

        // Flush
        do_reset();
        drv(1, 1, 2, 9, 0, 0); #1; chk("flush_rdy0", in_ready, 1);
        idle();
        drv(0, 0, 0, 0, 0, 1); #1; chk("flush_rdy_in_flush", in_ready, 0);
        drv(1, 9, 0, 10, 0, 0); #1;
        chk("flush_consumer_rdy", in_ready, 1);
        chk("flush_no_wb", wb_valid, 0);
        chk("flush_busy", busy, 0);
        repeat (6) idle();

        // Saturation of the narrow counter: 20 refused cycles via flush
        repeat (20) drv(1, 1, 1, 1, 0, 1);
        idle(); #1; chk("sat_w4", b_stall_count, 15);
        repeat (2) idle();

        // Random traffic with a mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            drv($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 49) == 0);
        end
        repeat (8) idle();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
